// File: rtl/avg_threshold_detector.sv
// avg_threshold_detector: hysteresis and debounce level detector placed
// after the moving-average stage. Each strobed sample is compared against
// the programmable high and low thresholds, and the detector produces a
// debounced level, rise/fall pulses and a saturating rise counter.
//
// Optional feature macro: PEAK_HOLD_EN. When it is defined, the design
// records the maximum sample of each high episode. When it is undefined,
// peak_o and peak_valid_o are tied to 0.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   data_i       in   averaged sample, valid while strobe_i=1
//   strobe_i     in   sample-valid pulse; may stay high on consecutive cycles
//   thr_hi_i     in   upper threshold, unsigned, sampled with data_i
//   thr_lo_i     in   lower threshold, unsigned, sampled with data_i
//   clear_i      in   synchronous clear of the event counter and peak state
//   level_o      out  debounced level, 1 = high region
//   rise_o       out  one-cycle pulse on a 0->1 level change
//   fall_o       out  one-cycle pulse on a 1->0 level change
//   event_cnt_o  out  number of rises, saturating
//   cfg_err_o    out  last strobed sample had thr_lo_i > thr_hi_i
//   peak_o       out  maximum sample of the last completed high episode
//   peak_valid_o out  one-cycle pulse when peak_o updates

module avg_threshold_detector #(
    parameter int DATA_W   = 10,
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_i,
    input  logic              strobe_i,
    input  logic [DATA_W-1:0] thr_hi_i,
    input  logic [DATA_W-1:0] thr_lo_i,
    input  logic              clear_i,
    output logic              level_o,
    output logic              rise_o,
    output logic              fall_o,
    output logic [CNT_W-1:0]  event_cnt_o,
    output logic              cfg_err_o,
    output logic [DATA_W-1:0] peak_o,
    output logic              peak_valid_o
);

    // Bit 1 of the state encoding is the level, so level_o can be read
    // straight from the next state.
    localparam logic [1:0] S_LOW      = 2'd0;
    localparam logic [1:0] S_ARM_HIGH = 2'd1;
    localparam logic [1:0] S_HIGH     = 2'd2;
    localparam logic [1:0] S_ARM_LOW  = 2'd3;

    localparam logic [3:0]       DEB     = 4'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] deb_cnt;
    logic [3:0] deb_nxt;
    logic [3:0] deb_inc;
    logic       rise_nxt;
    logic       fall_nxt;
    logic       cfg_bad;
    logic       accept;
    logic       hi_hit;
    logic       lo_hit;

    assign cfg_bad = thr_lo_i > thr_hi_i;
    // A sample with inverted thresholds is dropped entirely. It neither
    // advances nor breaks an arm sequence.
    assign accept  = strobe_i && !cfg_bad;
    assign hi_hit  = data_i >= thr_hi_i;
    assign lo_hit  = data_i <= thr_lo_i;
    assign deb_inc = deb_cnt + 4'd1;

    always_comb begin
        state_nxt = state;
        deb_nxt   = deb_cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (accept) begin
            case (state)
                S_LOW: begin
                    if (hi_hit) begin
                        if (DEB == 4'd1) begin
                            state_nxt = S_HIGH;
                            deb_nxt   = 4'd0;
                            rise_nxt  = 1'b1;
                        end else begin
                            state_nxt = S_ARM_HIGH;
                            deb_nxt   = 4'd1;
                        end
                    end
                end
                S_ARM_HIGH: begin
                    if (hi_hit) begin
                        if (deb_inc == DEB) begin
                            state_nxt = S_HIGH;
                            deb_nxt   = 4'd0;
                            rise_nxt  = 1'b1;
                        end else begin
                            deb_nxt = deb_inc;
                        end
                    end else begin
                        // Any in-band or low sample breaks arming.
                        state_nxt = S_LOW;
                        deb_nxt   = 4'd0;
                    end
                end
                S_HIGH: begin
                    if (lo_hit) begin
                        if (DEB == 4'd1) begin
                            state_nxt = S_LOW;
                            deb_nxt   = 4'd0;
                            fall_nxt  = 1'b1;
                        end else begin
                            state_nxt = S_ARM_LOW;
                            deb_nxt   = 4'd1;
                        end
                    end
                end
                S_ARM_LOW: begin
                    if (lo_hit) begin
                        if (deb_inc == DEB) begin
                            state_nxt = S_LOW;
                            deb_nxt   = 4'd0;
                            fall_nxt  = 1'b1;
                        end else begin
                            deb_nxt = deb_inc;
                        end
                    end else begin
                        state_nxt = S_HIGH;
                        deb_nxt   = 4'd0;
                    end
                end
                default: begin
                    state_nxt = S_LOW;
                    deb_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_LOW;
            deb_cnt     <= 4'd0;
            level_o     <= 1'b0;
            rise_o      <= 1'b0;
            fall_o      <= 1'b0;
            cfg_err_o   <= 1'b0;
            event_cnt_o <= '0;
        end else begin
            state   <= state_nxt;
            deb_cnt <= deb_nxt;
            level_o <= state_nxt[1];
            rise_o  <= rise_nxt;
            fall_o  <= fall_nxt;
            if (strobe_i) begin
                cfg_err_o <= cfg_bad;
            end
            // A clear on the same edge as a rise still counts that rise.
            if (clear_i) begin
                event_cnt_o <= rise_nxt ? CNT_W'(1) : '0;
            end else if (rise_nxt && event_cnt_o != CNT_MAX) begin
                event_cnt_o <= event_cnt_o + CNT_W'(1);
            end
        end
    end

`ifdef PEAK_HOLD_EN
    logic [DATA_W-1:0] run_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            run_max      <= '0;
            peak_o       <= '0;
            peak_valid_o <= 1'b0;
        end else begin
            // The episode starts from the sample that completes the rise.
            if (rise_nxt) begin
                run_max <= data_i;
            end else if (clear_i) begin
                run_max <= '0;
            end else if (accept && state[1] && data_i > run_max) begin
                run_max <= data_i;
            end
            // A fall capture takes priority over a coincident clear.
            if (fall_nxt) begin
                peak_o <= run_max;
            end else if (clear_i) begin
                peak_o <= '0;
            end
            peak_valid_o <= fall_nxt;
        end
    end
`else
    assign peak_o       = '0;
    assign peak_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_avg_threshold_detector.sv
// Directed testbench for avg_threshold_detector with DEBOUNCE=3,
// DATA_W=10 and CNT_W=8.
module tb_avg_threshold_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] data_i;
    logic       strobe_i;
    logic [9:0] thr_hi_i;
    logic [9:0] thr_lo_i;
    logic       clear_i;
    logic       level_o;
    logic       rise_o;
    logic       fall_o;
    logic [7:0] event_cnt_o;
    logic       cfg_err_o;
    logic [9:0] peak_o;
    logic       peak_valid_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    avg_threshold_detector #(
        .DATA_W(10),
        .DEBOUNCE(3),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .data_i(data_i),
        .strobe_i(strobe_i),
        .thr_hi_i(thr_hi_i),
        .thr_lo_i(thr_lo_i),
        .clear_i(clear_i),
        .level_o(level_o),
        .rise_o(rise_o),
        .fall_o(fall_o),
        .event_cnt_o(event_cnt_o),
        .cfg_err_o(cfg_err_o),
        .peak_o(peak_o),
        .peak_valid_o(peak_valid_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one clock cycle with the given inputs. Outputs are then read
    // 1 time unit after the rising edge.
    task automatic cyc(input logic s, input int d, input int hi,
                       input int lo, input logic clr, input logic rst);
        @(negedge clk);
        strobe_i = s;
        data_i   = 10'(d);
        thr_hi_i = 10'(hi);
        thr_lo_i = 10'(lo);
        clear_i  = clr;
        reset    = rst;
        @(posedge clk);
        #1;
        strobe_i = 1'b0;
        clear_i  = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic smp(input int d);
        cyc(1'b1, d, 600, 400, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 0, 600, 400, 1'b0, 1'b0);
    endtask

    logic [9:0] pk_exp;

    initial begin
        reset = 1'b1; strobe_i = 1'b0; clear_i = 1'b0;
        data_i = '0; thr_hi_i = '0; thr_lo_i = '0;

        // Reset state.
        cyc(1'b1, 700, 600, 400, 1'b0, 1'b1);
        cyc(1'b0, 0, 600, 400, 1'b0, 1'b1);
        chk("rst_level", 32'(level_o), 0);
        chk("rst_rise", 32'(rise_o), 0);
        chk("rst_fall", 32'(fall_o), 0);
        chk("rst_cnt", 32'(event_cnt_o), 0);
        chk("rst_cfg", 32'(cfg_err_o), 0);
        chk("rst_peak", 32'(peak_o), 0);
        chk("rst_pv", 32'(peak_valid_o), 0);

        // Basic rise after three hi samples.
        smp(700); chk("r1_lvl", 32'(level_o), 0);
        smp(700); chk("r2_lvl", 32'(level_o), 0);
        smp(700);
        chk("r3_lvl", 32'(level_o), 1);
        chk("r3_rise", 32'(rise_o), 1);
        chk("r3_cnt", 32'(event_cnt_o), 1);
        idle();
        chk("r_rise_w", 32'(rise_o), 0);
        chk("r_lvl_h", 32'(level_o), 1);

        // A mid-band sample breaks falling arm.
        smp(350); smp(350); smp(500);
        chk("brk_lvl", 32'(level_o), 1);
        smp(350); smp(350);
        chk("f2_fall", 32'(fall_o), 0);
        chk("f2_lvl", 32'(level_o), 1);
        smp(350);
        chk("f3_fall", 32'(fall_o), 1);
        chk("f3_rise", 32'(rise_o), 0);
        chk("f3_lvl", 32'(level_o), 0);
`ifdef PEAK_HOLD_EN
        pk_exp = 10'd700;
        chk("f3_pv", 32'(peak_valid_o), 1);
`else
        pk_exp = 10'd0;
        chk("f3_pv", 32'(peak_valid_o), 0);
`endif
        chk("f3_peak", 32'(peak_o), 32'(pk_exp));
        idle();
        chk("f_fall_w", 32'(fall_o), 0);
        chk("f_pv_w", 32'(peak_valid_o), 0);

        // An inverted-threshold sample is ignored and does not break arm.
        smp(700); smp(700);
        cyc(1'b1, 700, 600, 650, 1'b0, 1'b0);
        chk("cfg_err", 32'(cfg_err_o), 1);
        chk("cfg_lvl", 32'(level_o), 0);
        idle();
        chk("cfg_hold", 32'(cfg_err_o), 1);
        smp(700);
        chk("cfg_clr", 32'(cfg_err_o), 0);
        chk("cfg_rise", 32'(level_o), 1);
        chk("cfg_cnt", 32'(event_cnt_o), 2);
        smp(350); smp(350); smp(350);
        chk("cfg_fall", 32'(level_o), 0);

        // Peak episode.
        smp(700); smp(800); smp(950);
        chk("pk_rise", 32'(rise_o), 1);
        smp(720); smp(300); smp(300); smp(300);
        chk("pk_fall", 32'(fall_o), 1);
`ifdef PEAK_HOLD_EN
        pk_exp = 10'd950;
        chk("pk_pv", 32'(peak_valid_o), 1);
`else
        pk_exp = 10'd0;
        chk("pk_pv", 32'(peak_valid_o), 0);
`endif
        chk("pk_val", 32'(peak_o), 32'(pk_exp));
        chk("pk_cnt", 32'(event_cnt_o), 3);

        // Samples exactly on the thresholds qualify.
        smp(600); smp(600); smp(600);
        chk("eq_hi", 32'(level_o), 1);
        smp(400); smp(400); smp(400);
        chk("eq_lo", 32'(level_o), 0);
        chk("eq_cnt", 32'(event_cnt_o), 4);

        // Reset in the middle of arming.
        smp(700); smp(700);
        cyc(1'b1, 700, 600, 400, 1'b0, 1'b1);
        chk("ra_lvl", 32'(level_o), 0);
        chk("ra_cnt", 32'(event_cnt_o), 0);
        chk("ra_rise", 32'(rise_o), 0);
        smp(700); smp(700);
        chk("ra_2hit", 32'(level_o), 0);
        smp(700);
        chk("ra_3hit", 32'(level_o), 1);
        chk("ra_cnt1", 32'(event_cnt_o), 1);
        smp(300); smp(300); smp(300);

        // Saturate the counter, then clear on a rise.
        for (int i = 0; i < 300; i++) begin
            smp(700); smp(700); smp(700);
            smp(300); smp(300); smp(300);
        end
        chk("sat_cnt", 32'(event_cnt_o), 255);
        smp(700); smp(700);
        cyc(1'b1, 700, 600, 400, 1'b1, 1'b0);
        chk("clr_rise", 32'(event_cnt_o), 1);
        chk("clr_lvl", 32'(level_o), 1);
        cyc(1'b0, 0, 600, 400, 1'b1, 1'b0);
        chk("clr_only", 32'(event_cnt_o), 0);
        chk("clr_lvl2", 32'(level_o), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
